// File: rtl/counter_pkg.sv
// Shared timing-path types: timer FSM encoding and default widths.
// Imported by down_timer_m.
package counter_pkg;

  localparam int WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } timer_state_e;

endpackage

// File: rtl/down_timer_m.sv
// Loadable down-counting timer with done/ack handshake.
// Optional DOWN_TIMER_AUTO_RELOAD_EN: periodic reload with one-cycle done pulse.
module down_timer_m
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d  = data;
      state_d  = IDLE;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      reload_d = data;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = (count_q == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (count_q <= ONE) begin
            // Terminal count: the <= also guards against wrap below 0
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            if (reload_q != '0) begin
              count_d = reload_q;
              done_d  = 1'b1;
            end else begin
              count_d = '0;
              state_d = DONE;
            end
`else
            count_d = '0;
            state_d = DONE;
`endif
          end else begin
            count_d = count_q - ONE;
          end
        end
        PAUSE: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (ack) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_d == DONE) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign count = count_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = done_q;

endmodule
